keyspace_enumerator: RTL
========================

# keyspace_enumerator

Parametrised brute-force candidate generator: enumerates every string over a selected charset for all lengths from `min_len` to `max_len`, emitting one candidate per cycle to a hash core over a valid/ready stream. It succeeds the fixed 16-character counter with configurable length range, backpressure, an explicit run/done state machine, and stride/offset interleaving so N hash cores can partition one keyspace without overlap.

## Interface
- `MAX_LEN`, 16: maximum candidate length in characters (1..32).
- `CHAR_W`, 8: bits per output character.
- `IDX_W`, 9: digit index width (must hold 256).
- `CNT_W`, 64: emitted-candidate counter width.

- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches config, honoured only in IDLE.
- `abort`  in  1  return to IDLE next cycle; in-flight candidates are discarded.
- `charset`  in  3  charset id (0 lower 26, 1 upper 26, 2 alpha 52, 3 alnum 62, 4 printable 94, 5 full 256).
- `min_len`, `max_len`  in  $clog2(MAX_LEN+1) each  inclusive length range.
- `stride`  in  IDX_W  digit-0 step (1..charset size); equals core count.
- `offset`  in  IDX_W  initial digit-0 index (< stride); the core's slot.
- `out_valid`  out  1  candidate present.
- `out_ready`  in  1  consumer accepts; transfer when both high.
- `out_guess`  out  MAX_LEN*CHAR_W  char 0 in the most-significant byte; bytes at or beyond `out_len` are zero.
- `out_len`  out  $clog2(MAX_LEN+1)  length of `out_guess`.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the final candidate transfers.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.
- `count`  out  CNT_W  transfers since the last accepted `start`.

## Operation
- States: IDLE -> (start, cfg ok) RUN -> (last candidate entered pipeline) DRAIN -> (last transfer) IDLE with `done`. `abort` in any state -> IDLE.
- Config is rejected, with a `cfg_err` pulse and the block staying in IDLE, for any of: charset > 5, min_len = 0, min_len > max_len, max_len > MAX_LEN, stride = 0, stride > size, offset >= stride.
- Counter: digits d[0..MAX_LEN-1], little-endian; d[0] is the fastest-moving digit and maps to character 0. Load: d[0] = offset, all other digits 0, L = min_len.
- Advance: d[0] += stride. If the sum is >= size, d[0] = sum - size and a carry goes into d[1]. Carries ripple as +1, wrapping at size-1 -> 0, through d[L-1]; lookahead is permitted.
- Carry out of d[L-1]: if L < max_len, L += 1 and reload the digits as at load time. Otherwise the current candidate is the last one.
- Character mapping: char = table[charset][d[i]] for i < L, else 0.
- `count` increments on every transfer and saturates at all-ones.

## Timing
- Reset values: state IDLE; `out_valid`, `busy`, `done`, `cfg_err` = 0; `out_guess`, `out_len`, `count` = 0.
- Pipeline has 2 stages: counter/address, then ROM/output register. The first `out_valid` rises 2 cycles after an accepted `start`.
- Throughput: 1 candidate/cycle while `out_ready` = 1.
- Stall: when `out_valid && !out_ready`, `out_guess` and `out_len` hold stable and the counter freezes. No candidate is lost or duplicated.
- `done` asserts in the same cycle as the final transfer edge + 1. `busy` falls in that cycle.
- `start` while not IDLE is ignored without `cfg_err`. `start` and `abort` in the same cycle: abort wins.
- Reset mid-run behaves exactly like power-up.

## Structure
- Package `enum_pkg` holds:
  - charset id enum;
  - charset size constants (26, 26, 52, 62, 94, 256);
  - the state enum.
- Sub-module `charset_rom`: synchronous-read table, MAX_LEN read ports (dual-port banks, indexed by {charset, d[i][7:0]}). Order: lower a-z, upper A-Z, alpha a-zA-Z, alnum a-zA-Z0-9, printable 0x21-0x7E, full 0x00-0xFF.

## Test plan
- Charset 0, len 1..1, stride 1, offset 0, ready high -> "a".."z" on consecutive cycles; `done` after 26; `count` = 26.
- Charset 3, len 1..2, stride 1 -> 62 + 3844 = 3906 candidates. The 63rd is "aa" with `out_len` = 2; the last is "99".
- Stride 3, offsets 0/1/2 run in three instances, charset 0, len 2..2 -> union equals all 676 strings, with no duplicates.
- Random `out_ready` at 30% duty, charset 4, len 1..2 -> the sequence is identical to the ready-high run and `out_guess` is stable during stalls.
- Invalid configs: min_len 3 / max_len 2; stride 0; offset 2 with stride 2 -> `cfg_err` pulse only, `busy` stays 0.
- `abort`, then `reset` low, each mid-run -> IDLE next cycle with `out_valid` 0; a fresh `start` restarts at offset/min_len and `count` restarts from 0.

Source files
------------

// File: rtl/enum_pkg.sv
// Shared types and charset tables for the keyspace enumerator.
// cs_char is the single source of truth for the character order of every charset.
package enum_pkg;

   typedef enum logic [2:0] {
      CS_LOWER = 3'd0,
      CS_UPPER = 3'd1,
      CS_ALPHA = 3'd2,
      CS_ALNUM = 3'd3,
      CS_PRINT = 3'd4,
      CS_FULL  = 3'd5
   } charset_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   localparam logic [8:0] SIZE_LOWER = 9'd26;
   localparam logic [8:0] SIZE_UPPER = 9'd26;
   localparam logic [8:0] SIZE_ALPHA = 9'd52;
   localparam logic [8:0] SIZE_ALNUM = 9'd62;
   localparam logic [8:0] SIZE_PRINT = 9'd94;
   localparam logic [8:0] SIZE_FULL  = 9'd256;

   // Unknown ids report size 0 so any stride check against them fails.
   function automatic logic [8:0] cs_size(input logic [2:0] cs);
      case (charset_e'(cs))
         CS_LOWER: cs_size = SIZE_LOWER;
         CS_UPPER: cs_size = SIZE_UPPER;
         CS_ALPHA: cs_size = SIZE_ALPHA;
         CS_ALNUM: cs_size = SIZE_ALNUM;
         CS_PRINT: cs_size = SIZE_PRINT;
         CS_FULL:  cs_size = SIZE_FULL;
         default:  cs_size = 9'd0;
      endcase
   endfunction

   // addr = {charset, digit}
   function automatic logic [7:0] cs_char(input logic [10:0] addr);
      logic [7:0] i;
      i = addr[7:0];
      case (charset_e'(addr[10:8]))
         CS_LOWER: cs_char = 8'h61 + i;
         CS_UPPER: cs_char = 8'h41 + i;
         CS_ALPHA: cs_char = (i < 8'd26) ? 8'h61 + i : 8'h41 + i - 8'd26;
         CS_ALNUM: cs_char = (i < 8'd26) ? 8'h61 + i :
                             (i < 8'd52) ? 8'h41 + i - 8'd26 : 8'h30 + i - 8'd52;
         CS_PRINT: cs_char = 8'h21 + i;
         default:  cs_char = i;
      endcase
   endfunction

endpackage

// File: rtl/keyspace_enumerator_if.sv
// Candidate stream from the enumerator to a hash core (valid/ready).
interface keyspace_enumerator_if #(
   parameter int MAX_LEN = 16,
   parameter int CHAR_W  = 8
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic                      out_valid;
   logic                      out_ready;
   logic [MAX_LEN*CHAR_W-1:0] out_guess;
   logic [LEN_W-1:0]          out_len;

   modport master (output out_valid, output out_guess, output out_len, input out_ready);
   modport slave  (input out_valid, input out_guess, input out_len, output out_ready);
endinterface

// File: rtl/charset_rom.sv
// Synchronous-read charset table, one read port per digit; disabled ports hold.
// Ports flagged by zero[] (digits beyond the current length) register 0.
module charset_rom
   import enum_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int CHAR_W  = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             en,
   input  logic [2:0]                       cs,
   input  logic [MAX_LEN-1:0][7:0]          idx,
   input  logic [MAX_LEN-1:0]               zero,
   output logic [MAX_LEN-1:0][CHAR_W-1:0]   q
);

   for (genvar i = 0; i < MAX_LEN; i++) begin : g_port
      logic [CHAR_W-1:0] q_r;

      always_ff @(posedge clk) begin
         if (!reset)  q_r <= '0;
         else if (en) q_r <= zero[i] ? '0 : CHAR_W'(cs_char({cs, idx[i]}));
      end

      assign q[i] = q_r;
   end

endmodule

// File: rtl/keyspace_enumerator.sv
// Brute-force candidate generator: strided mixed-radix counter -> address reg -> ROM/output reg.
// A single stall enable freezes the whole pipeline while the output is held.
module keyspace_enumerator
   import enum_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int CHAR_W  = 8,
   parameter int IDX_W   = 9,
   parameter int CNT_W   = 64,
   localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2:0]           charset,
   input  logic [LEN_W-1:0]     min_len,
   input  logic [LEN_W-1:0]     max_len,
   input  logic [IDX_W-1:0]     stride,
   input  logic [IDX_W-1:0]     offset,
   keyspace_enumerator_if.master stream,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   output logic [CNT_W-1:0]     count
);

   localparam int STAGES = 2;

   state_e                          state_q, state_d;
   logic [2:0]                      cs_q;
   logic [LEN_W-1:0]                max_q, len_q, len_d, a_len, olen_q;
   logic [IDX_W-1:0]                stride_q, offset_q, size;
   logic [MAX_LEN-1:0][IDX_W-1:0]   d_q, d_d;
   logic [MAX_LEN-1:0][7:0]         a_d;
   logic [MAX_LEN-1:0]              zero, carry;
   logic [MAX_LEN-1:0][CHAR_W-1:0]  rom_q;
   logic [MAX_LEN*CHAR_W-1:0]       guess_w;
   logic [STAGES:1]                 vld_q;
   logic [STAGES:0]                 vld_pipe;
   logic [IDX_W:0]                  sum;
   logic                            en, xfer, go, cfg_ok, accept, emit, wrap, last;

   assign size     = IDX_W'(cs_size(cs_q));
   assign vld_pipe = {vld_q, state_q == S_RUN};
   assign en       = !(vld_q[STAGES] && !stream.out_ready);
   assign xfer     = vld_q[STAGES] && stream.out_ready;
   assign go       = (state_q == S_IDLE) && start && !abort;
   assign emit     = (state_q == S_RUN) && en;
   assign accept   = go && cfg_ok;
   assign busy     = (state_q != S_IDLE);

   assign cfg_ok = (charset <= 3'd5) && (min_len != '0) && (min_len <= max_len) &&
                   (max_len <= LEN_W'(MAX_LEN)) && (stride != '0) &&
                   (stride <= IDX_W'(cs_size(charset))) && (offset < stride);

   // Digit 0 steps by stride; higher digits take +1 carries up to d[L-1].
   always_comb begin
      d_d      = d_q;
      len_d    = len_q;
      carry    = '0;
      wrap     = 1'b0;
      last     = 1'b0;
      sum      = {1'b0, d_q[0]} + {1'b0, stride_q};
      carry[0] = (sum >= {1'b0, size});
      d_d[0]   = carry[0] ? IDX_W'(sum - {1'b0, size}) : IDX_W'(sum);
      for (int i = 1; i < MAX_LEN; i++) begin
         if (LEN_W'(i) < len_q) begin
            carry[i] = carry[i-1] && (d_q[i] == size - 1'b1);
            if (carry[i-1]) d_d[i] = carry[i] ? '0 : d_q[i] + 1'b1;
         end
      end
      for (int i = 0; i < MAX_LEN; i++)
         if (LEN_W'(i + 1) == len_q) wrap = carry[i];
      if (wrap) begin
         if (len_q < max_q) begin
            len_d  = len_q + 1'b1;
            d_d    = '0;
            d_d[0] = offset_q;
         end else begin
            last = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (emit && last) state_d = S_DRAIN;
         S_DRAIN: if (xfer && !vld_q[1]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cs_q     <= '0;
         max_q    <= '0;
         len_q    <= '0;
         stride_q <= '0;
         offset_q <= '0;
         d_q      <= '0;
         a_d      <= '0;
         a_len    <= '0;
         olen_q   <= '0;
         vld_q    <= '0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         count    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cs_q     <= charset;
            max_q    <= max_len;
            stride_q <= stride;
            offset_q <= offset;
            len_q    <= min_len;
            d_q      <= '0;
            d_q[0]   <= offset;
         end else if (emit) begin
            d_q   <= d_d;
            len_q <= len_d;
         end
         if (abort)   vld_q <= '0;
         else if (en) vld_q <= vld_pipe[STAGES-1:0];
         if (en) begin
            for (int i = 0; i < MAX_LEN; i++) a_d[i] <= d_q[i][7:0];
            a_len  <= len_q;
            olen_q <= a_len;
         end
         done    <= !abort && (state_q == S_DRAIN) && xfer && !vld_q[1];
         cfg_err <= go && !cfg_ok;
         if (accept)                count <= '0;
         else if (xfer && ~&count)  count <= count + 1'b1;
      end
   end

   always_comb begin
      zero    = '0;
      guess_w = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         zero[i] = (LEN_W'(i) >= a_len);
         guess_w[(MAX_LEN-1-i)*CHAR_W +: CHAR_W] = rom_q[i];
      end
   end

   charset_rom #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) u_rom (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .cs    (cs_q),
      .idx   (a_d),
      .zero  (zero),
      .q     (rom_q)
   );

   assign stream.out_valid = vld_q[STAGES];
   assign stream.out_guess = guess_w;
   assign stream.out_len   = olen_q;

endmodule
